// File: rtl/apb_mem_completer.sv
// APB completer backed by a word-addressed memory window.
// Each transfer is captured in the setup phase, held for a programmable
// number of wait cycles, then completed with PSLVERR for misaligned or
// out-of-window addresses. Byte strobes select which lanes a write updates.
//
// Ports:
//   clk, rst_n      single clock, async active-low reset
//   psel_i          APB select
//   penable_i       APB access phase
//   pwrite_i        1 = write, 0 = read
//   paddr_i         byte address
//   pwdata_i        write data
//   pstrb_i         byte-lane write enables
//   wait_cfg_i      wait cycles for this transfer, sampled in setup
//   pready_o        transfer complete
//   prdata_o        read data, nonzero only in the completion cycle
//   pslverr_o       error flag, only in the completion cycle
module apb_mem_completer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LG2  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic [3:0]            pstrb_i,
  input  logic [3:0]            wait_cfg_i,
  output logic                  pready_o,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pslverr_o
);

  localparam int                    DEPTH     = 1 << DEPTH_LG2;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4) << DEPTH_LG2;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DEPTH_LG2-1:0]   idx_q;
  logic                   wr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [3:0]             strb_q;
  logic                   err_q;
  logic                   load;
  logic                   done;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Offset from the window base; addresses below BASE_ADDR wrap to huge
  // unsigned values and so fall out of range on their own.
  logic [ADDR_WIDTH-1:0]  off_in;
  logic                   err_in;
  assign off_in = paddr_i - BASE_ADDR;
  assign err_in = (paddr_i[1:0] != 2'b00) || (off_in >= WIN_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // penable without a setup phase is ignored here
        if (psel_i && !penable_i) begin
          load    = 1'b1;
          cnt_d   = wait_cfg_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;                 // aborted: no write, no response
        end else if (penable_i) begin
          if (cnt_q == 4'd0) begin
            done    = 1'b1;
            state_d = IDLE;               // IDLE picks up a back-to-back setup
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; address/data changes during ACCESS are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      idx_q   <= off_in[DEPTH_LG2+1:2];
      wr_q    <= pwrite_i;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
      err_q   <= err_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++)
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign pready_o  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr_o = done && err_q;
  assign prdata_o  = (done && !wr_q && !err_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Self-checking bench for apb_mem_completer: table of transfers driven
// back-to-back through a scoreboard, plus hand sequences for abort,
// penable-in-idle and reset during an access.
module tb_apb_mem_completer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb, wait_cfg;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic        err;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  wt;
    logic [31:0] exp;
    logic        err;
  } vec_t;
  vec_t tbl[18];

  apb_mem_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LG2(8), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .wait_cfg_i(wait_cfg), .pready_o(pready), .prdata_o(prdata),
    .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 after completion so a following
  // call forms a back-to-back transfer.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] wt,
                      input logic [31:0] exp_rd, input logic exp_err);
    sb_t e;
    int  waits;
    bit  got;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    pstrb = s; wait_cfg = wt;
    e.rd = !w; e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    chk("setup_pready", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;
    // scramble inputs: the latched request must be used
    penable = 1'b1; paddr = ~a; pwdata = ~d; pstrb = ~s; pwrite = ~w; wait_cfg = ~wt;
    waits = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (pready) begin
        got = 1;
        e = sb.pop_front();
        chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
        if (e.rd) chk("prdata", prdata, e.rdata);
        chk("wait_count", waits, {28'b0, wt});
      end else begin
        chk("prdata_wait", prdata, 32'd0);
        chk("pslverr_wait", {31'b0, pslverr}, 32'd0);
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout: no pready for addr %h", a);
      void'(sb.pop_front());
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 4'd0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h010, 32'h0,        4'h0, 4'd3, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h020, 32'hFFFFFFFF, 4'hF, 4'd1, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 32'h020, 32'h11223344, 4'h5, 4'd0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h020, 32'h0,        4'h0, 4'd2, 32'hFF22FF44, 1'b0};
    tbl[6]  = '{1'b1, 32'h000, 32'hA5A5A5A5, 4'hF, 4'd0, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 4'd1, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 32'h400, 32'h12345678, 4'hF, 4'd0, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 4'd0, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b0, 32'h000, 32'h0,        4'h0, 4'd0, 32'hA5A5A5A5, 1'b0};
    tbl[11] = '{1'b0, 32'h400, 32'h0,        4'h0, 4'd1, 32'h0,        1'b1};
    tbl[12] = '{1'b1, 32'h002, 32'hFFFFFFFF, 4'hF, 4'd0, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 32'h000, 32'h0,        4'h0, 4'd0, 32'hA5A5A5A5, 1'b0};
    tbl[14] = '{1'b0, 32'h002, 32'h0,        4'h0, 4'd0, 32'h0,        1'b1};
    tbl[15] = '{1'b1, 32'h004, 32'h77665544, 4'h8, 4'd2, 32'h0,        1'b0};
    tbl[16] = '{1'b0, 32'h004, 32'h0,        4'h0, 4'd0, 32'h77000000, 1'b0};
    tbl[17] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 4'd0, 32'h0,        1'b1};

    rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pstrb = 0; wait_cfg = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", {31'b0, pready}, 32'd0);
    chk("reset_prdata", prdata, 32'd0);
    chk("reset_pslverr", {31'b0, pslverr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].wt, tbl[i].exp, tbl[i].err);

    // abort: psel dropped in the 2nd wait cycle of a write with 4 waits
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h030; pwdata = 32'h12345678;
    pstrb = 4'hF; wait_cfg = 4'd4;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("abort_wait1_pready", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_pready", {31'b0, pready}, 32'd0);
    end
    @(posedge clk); #1;
    xfer(1'b0, 32'h030, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);

    // penable without psel/setup in IDLE is ignored
    penable = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_penable_pready", {31'b0, pready}, 32'd0);
    end
    @(posedge clk); #1;
    penable = 0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h010, 32'h0, 4'h0, 4'd1, 32'hDEADBEEF, 1'b0);

    // reset during a completion cycle: outputs must drop without a clock edge
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h010; wait_cfg = 4'd0;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("pre_rst_pready", {31'b0, pready}, 32'd1);
    chk("pre_rst_prdata", prdata, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pready", {31'b0, pready}, 32'd0);
    chk("async_rst_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset during a wait cycle of a write
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h040; pwdata = 32'h55AA55AA;
    pstrb = 4'hF; wait_cfg = 4'd5;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_pready", {31'b0, pready}, 32'd0);
    chk("rst_wait_prdata", prdata, 32'd0);
    chk("rst_wait_pslverr", {31'b0, pslverr}, 32'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h040, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
    xfer(1'b0, 32'h020, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
    xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 4'd2, 32'h0, 1'b0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/apb_mem_completer.md
Name: apb_mem_completer

Overview:
- APB completer (responder) at the far end of the AXI-to-APB bridge's APB master port.
- Backs a word-addressed register/memory array with programmable wait states, byte strobes and PSLVERR on bad addresses.
- Serves as the bridge's downstream target in system simulation and as a reusable peripheral shell.

Parameters:
ADDR_WIDTH, 32, APB address width in bits.
DATA_WIDTH, 32, APB data width in bits. Fixed at 32; strobe is 4 bits.
DEPTH_LG2, 8, log2 of the number of 32-bit words (256 words = 1 KiB window).
BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be aligned to the window size.

Ports:
clk  input  1  Single clock. All state changes on the rising edge.
rst_n  input  1  Asynchronous, active-low reset.
psel_i  input  1  APB select.
penable_i  input  1  APB enable (access phase).
pwrite_i  input  1  1 = write (WRITE), 0 = read (READ).
paddr_i  input  ADDR_WIDTH  Byte address.
pwdata_i  input  DATA_WIDTH  Write data.
pstrb_i  input  4  Byte-lane write enables.
wait_cfg_i  input  4  Number of wait cycles to insert. Sampled at the setup phase.
pready_o  output  1  Transfer complete.
prdata_o  output  DATA_WIDTH  Read data. Valid only in the completion cycle.
pslverr_o  output  1  Error flag. Valid only in the completion cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the wait counter clears.
  - pready_o=0, prdata_o=0, pslverr_o=0.
  - All memory words are cleared to 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel_i=1 and penable_i=0 (setup phase), latch paddr_i, pwrite_i, pwdata_i and pstrb_i.
  - Load the counter with wait_cfg_i.
  - Compute err = (paddr_i[1:0]!=0) or (paddr_i-BASE_ADDR >= 4<<DEPTH_LG2), using unsigned arithmetic. Addresses below BASE_ADDR wrap to large values and are therefore errors.
  - Go to ACCESS.
- ACCESS:
  - pready_o = (cnt==0), combinational from registered state.
  - While psel_i=1, penable_i=1 and cnt!=0: decrement cnt.
  - Completion cycle (psel_i=1, penable_i=1, cnt==0):
    - pready_o=1 and pslverr_o=err.
    - Read: prdata_o = err ? 0 : mem[latched word index].
    - Write with err=0: each byte lane i with pstrb_lat[i]=1 is updated from pwdata_lat at the clock edge ending the cycle. Lanes with strobe 0 keep their old value.
    - Write with err=1: dropped; memory unchanged.
  - After completion:
    - If psel_i=1 and penable_i=0 on the next cycle, that cycle is a new setup, handled exactly as in IDLE (back-to-back transfers, no idle gap required).
    - Otherwise return to IDLE.
- Outside the completion cycle: pready_o=0 in IDLE; prdata_o=0 and pslverr_o=0.
- Latency: an access phase lasts wait_cfg_i+1 cycles. With wait_cfg_i=0 there are zero wait states.
- Protocol violations:
  - psel_i drops while in ACCESS: abort to IDLE, no memory write, no response.
  - penable_i=1 while in IDLE: ignored.
  - Changes to the address or data inputs during ACCESS are ignored; the latched values are used.
- Reset asserted mid-access: the transfer is abandoned, memory clears, and the block is in IDLE on the first edge after rst_n rises.
- Word index = (paddr_lat-BASE_ADDR)[DEPTH_LG2+1:2].
- Highest valid address is BASE_ADDR + (4<<DEPTH_LG2) - 4. The next word up is out of range.

Test Plan:
1. Zero wait: wait_cfg=0, write 0xDEADBEEF to 0x10 with strb=4'hF, then read 0x10 -> pready=1 on the first access cycle of each transfer; read returns 0xDEADBEEF; pslverr=0.
2. Wait states: wait_cfg=3, read 0x10 -> pready=0 for 3 access cycles, then pready=1 with prdata valid only in that cycle; prdata=0 in the other cycles.
3. Strobes: write 0xFFFFFFFF to 0x20 with strb=F, then write 0x11223344 with strb=4'b0101, then read -> 0xFF22FF44.
4. Errors (BASE_ADDR=0, DEPTH_LG2=8):
   - Write to 0x400 -> pslverr=1; a read of 0x3FC is unaffected and 0x3FC itself is accepted.
   - Write to 0x02 (misaligned) -> pslverr=1, and the word at 0x00 is unchanged.
5. Back-to-back and abort:
   - Two transfers with the setup phase immediately after completion -> both complete correctly.
   - psel dropped during the 2nd wait cycle of a write (wait_cfg=4) -> no pready, memory unchanged.
6. Reset mid-access: rst_n=0 during a wait cycle of a write -> all outputs 0 immediately; a subsequent read of any address returns 0.
